// File: rtl/drink_ctrl.sv
// -----------------------------------------------------------------------------
// drink_ctrl -- vending controller for the drink machine.
//
// Debounces the coin5 / coin10 / cancel buttons on the 20 ms tick, accumulates
// credit, and sequences dispense, change and refund through a four-state FSM
// (IDLE, COLLECT, DISPENSE, REFUND). The ticks are clock enables, not clocks.
//
// Ports
//   CP           in   system clock, rising edge
//   CR           in   synchronous active-high reset, overrides everything
//   tick_20ms    in   one-cycle enable, 50 Hz (debounce sampling)
//   tick_1s      in   one-cycle enable, 1 Hz (dispense / timeout timers)
//   coin5        in   raw 5-unit coin button
//   coin10       in   raw 10-unit coin button
//   cancel       in   raw cancel button
//   amount       out  current credit (8-bit unsigned)
//   dispense     out  drink valve on
//   change       out  change / refund value, qualified by change_valid
//   change_valid out  one-cycle pulse
//   busy         out  high in every state except IDLE
// -----------------------------------------------------------------------------
module drink_ctrl #(
  parameter int unsigned PRICE      = 25,
  parameter int unsigned DISPENSE_S = 3,
  parameter int unsigned TIMEOUT_S  = 10
) (
  input  logic       CP,
  input  logic       CR,
  input  logic       tick_20ms,
  input  logic       tick_1s,
  input  logic       coin5,
  input  logic       coin10,
  input  logic       cancel,
  output logic [7:0] amount,
  output logic       dispense,
  output logic [7:0] change,
  output logic       change_valid,
  output logic       busy
);

  localparam int TW = 16;
  localparam logic [7:0]    PRICE_C = 8'(PRICE);
  localparam logic [TW-1:0] DISP_LAST = TW'(DISPENSE_S - 1);
  localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT_S - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, DISPENSE, REFUND} state_t;

  // ---------------------------------------------------------------------------
  // Debounce: bit 0 = coin5, bit 1 = coin10, bit 2 = cancel
  // ---------------------------------------------------------------------------
  logic [2:0] raw;
  logic [2:0] evt;

  assign raw = {cancel, coin10, coin5};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_db
      logic smp_q;
      logic stb_q;
      logic evt_q;

      always_ff @(posedge CP) begin
        if (CR) begin
          smp_q <= 1'b0;
          stb_q <= 1'b0;
          evt_q <= 1'b0;
        end else begin
          evt_q <= 1'b0;
          if (tick_20ms) begin
            smp_q <= raw[gi];
            // Level must match on two consecutive ticks before it is accepted;
            // the event fires on the same edge stb goes 0->1.
            if (smp_q == raw[gi]) begin
              stb_q <= raw[gi];
              evt_q <= raw[gi] & ~stb_q;
            end
          end
        end
      end

      assign evt[gi] = evt_q;
    end
  endgenerate

  logic       coin5_ev, coin10_ev, cancel_ev, coin_any;
  logic [7:0] coin_val;

  assign coin5_ev  = evt[0];
  assign coin10_ev = evt[1];
  assign cancel_ev = evt[2];
  assign coin_any  = coin5_ev | coin10_ev;
  assign coin_val  = (coin5_ev ? 8'd5 : 8'd0) + (coin10_ev ? 8'd10 : 8'd0);

  // ---------------------------------------------------------------------------
  // FSM + datapath
  // ---------------------------------------------------------------------------
  state_t        state_q, state_d;
  logic [7:0]    amount_q, amount_d;
  logic [7:0]    change_q, change_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          dispense_q, dispense_d;
  logic          change_valid_q, change_valid_d;
  logic          busy_q, busy_d;
  logic [7:0]    sum;

  // State register
  always_ff @(posedge CP) begin
    if (CR) begin
      state_q        <= IDLE;
      amount_q       <= 8'd0;
      change_q       <= 8'd0;
      timer_q        <= '0;
      dispense_q     <= 1'b0;
      change_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      amount_q       <= amount_d;
      change_q       <= change_d;
      timer_q        <= timer_d;
      dispense_q     <= dispense_d;
      change_valid_q <= change_valid_d;
      busy_q         <= busy_d;
    end
  end

  // Next state and datapath
  always_comb begin
    state_d  = state_q;
    amount_d = amount_q;
    change_d = change_q;
    timer_d  = timer_q;
    sum      = amount_q + coin_val;

    case (state_q)
      IDLE: begin
        amount_d = 8'd0;
        timer_d  = '0;
        if (coin_any) begin
          amount_d = coin_val;
          state_d  = COLLECT;
        end
      end

      COLLECT: begin
        if (cancel_ev) begin
          change_d = sum;
          amount_d = sum;
          state_d  = REFUND;
        end else if (sum >= PRICE_C) begin
          change_d = sum - PRICE_C;
          amount_d = sum;
          timer_d  = '0;
          state_d  = DISPENSE;
        end else if (coin_any) begin
          // A coin on the final timeout tick still wins and restarts the timer.
          amount_d = sum;
          timer_d  = '0;
        end else if (tick_1s) begin
          if (timer_q == TOUT_LAST) begin
            change_d = amount_q;
            state_d  = REFUND;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end

      DISPENSE: begin
        // Button events are swallowed here; only the seconds tick matters.
        if (tick_1s) begin
          if (timer_q == DISP_LAST) begin
            amount_d = 8'd0;
            timer_d  = '0;
            state_d  = IDLE;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end

      REFUND: begin
        amount_d = 8'd0;
        timer_d  = '0;
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // Outputs: registered decodes of the next state so they line up with state_q
  always_comb begin
    busy_d         = (state_d != IDLE);
    dispense_d     = (state_d == DISPENSE);
    change_valid_d = (state_d == REFUND) ||
                     ((state_q == DISPENSE) && (state_d == IDLE));
  end

  assign amount       = amount_q;
  assign dispense     = dispense_q;
  assign change       = change_q;
  assign change_valid = change_valid_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_drink_ctrl.sv
// -----------------------------------------------------------------------------
// tb_drink_ctrl -- directed bench for drink_ctrl (PRICE=25, DISPENSE_S=3,
// TIMEOUT_S=10). Stimulus pushes expected change_valid transactions into a
// scoreboard queue; a negedge monitor pops and compares each pulse.
// -----------------------------------------------------------------------------
module tb_drink_ctrl;

  logic       CP = 1'b0;
  logic       CR = 1'b1;
  logic       tick_20ms = 1'b0;
  logic       tick_1s = 1'b0;
  logic       coin5 = 1'b0;
  logic       coin10 = 1'b0;
  logic       cancel = 1'b0;
  logic [7:0] amount;
  logic       dispense;
  logic [7:0] change;
  logic       change_valid;
  logic       busy;

  drink_ctrl #(.PRICE(25), .DISPENSE_S(3), .TIMEOUT_S(10)) dut (
    .CP(CP), .CR(CR), .tick_20ms(tick_20ms), .tick_1s(tick_1s),
    .coin5(coin5), .coin10(coin10), .cancel(cancel),
    .amount(amount), .dispense(dispense), .change(change),
    .change_valid(change_valid), .busy(busy)
  );

  always #5 CP = ~CP;

  typedef struct {
    int chg;    // expected change value
    int amt;    // expected amount during the pulse
    int ticks;  // expected tick_1s count seen while dispense was high
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end else begin
      $display("ok   %s: %0d", nm, act);
    end
  endtask

  // ---------------- monitor ----------------
  int   disp_ticks = 0;
  int   disp_cyc   = 0;
  logic prev_cv    = 1'b0;
  exp_t e;

  always @(negedge CP) begin
    if (CR) begin
      disp_ticks = 0;
      disp_cyc   = 0;
      prev_cv    = 1'b0;
    end else begin
      if (dispense) begin
        disp_cyc++;
        if (tick_1s) disp_ticks++;
      end
      if (change_valid) begin
        chk("cv_not_back_to_back", int'(prev_cv), 0);
        if (sb_q.size() == 0) begin
          chk("unexpected_change_valid", 1, 0);
        end else begin
          e = sb_q.pop_front();
          $display("txn: change=%0d amount=%0d disp_ticks=%0d", change, amount, disp_ticks);
          chk("txn_change", int'(change), e.chg);
          chk("txn_amount", int'(amount), e.amt);
          chk("txn_disp_ticks", disp_ticks, e.ticks);
          chk("txn_disp_seen", int'(disp_cyc != 0), int'(e.ticks != 0));
          chk("txn_dispense_low", int'(dispense), 0);
        end
        disp_ticks = 0;
        disp_cyc   = 0;
      end
      prev_cv = change_valid;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CP);
      #1;
    end
  endtask

  // 20 ms tick with a period of 3 cycles (odd, so per-cycle toggling aliases)
  task automatic t20();
    tick_20ms = 1'b1;
    cyc(1);
    tick_20ms = 1'b0;
    cyc(2);
  endtask

  task automatic sec();
    tick_1s = 1'b1;
    cyc(1);
    tick_1s = 1'b0;
    cyc(2);
  endtask

  task automatic press(input logic c5, input logic c10, input logic cc, input int n);
    coin5 = c5; coin10 = c10; cancel = cc;
    repeat (n) t20();
    coin5 = 1'b0; coin10 = 1'b0; cancel = 1'b0;
    repeat (3) t20();
  endtask

  function automatic exp_t mk(input int c, input int a, input int t);
    exp_t x;
    x.chg = c; x.amt = a; x.ticks = t;
    return x;
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    cyc(3);
    @(negedge CP);
    chk("reset_amount", int'(amount), 0);
    chk("reset_dispense", int'(dispense), 0);
    chk("reset_change", int'(change), 0);
    chk("reset_change_valid", int'(change_valid), 0);
    chk("reset_busy", int'(busy), 0);
    CR = 1'b0;
    cyc(2);

    // Exact price: 10 + 10 + 5
    press(0, 1, 0, 3);
    @(negedge CP); chk("exact_amt10", int'(amount), 10); chk("exact_busy", int'(busy), 1);
    press(0, 1, 0, 3);
    @(negedge CP); chk("exact_amt20", int'(amount), 20);
    sb_q.push_back(mk(0, 0, 3));
    press(1, 0, 0, 3);
    @(negedge CP); chk("exact_dispense_on", int'(dispense), 1);
    repeat (3) sec();
    cyc(2);
    @(negedge CP);
    chk("exact_end_amount", int'(amount), 0);
    chk("exact_end_busy", int'(busy), 0);

    // Overpay: 10 x3 -> change 5
    press(0, 1, 0, 3);
    press(0, 1, 0, 3);
    sb_q.push_back(mk(5, 0, 3));
    press(0, 1, 0, 3);
    @(negedge CP); chk("over_dispense_on", int'(dispense), 1);
    repeat (3) sec();
    cyc(2);

    // Cancel after coin5
    press(1, 0, 0, 3);
    @(negedge CP); chk("cancel_amt5", int'(amount), 5);
    sb_q.push_back(mk(5, 5, 0));
    press(0, 0, 1, 3);
    @(negedge CP); chk("cancel_idle_busy", int'(busy), 0);
    chk("cancel_idle_amount", int'(amount), 0);

    // Timeout after coin10
    press(0, 1, 0, 3);
    repeat (9) sec();
    @(negedge CP); chk("timeout_9_busy", int'(busy), 1); chk("timeout_9_amount", int'(amount), 10);
    sb_q.push_back(mk(10, 10, 0));
    tick_1s = 1'b1;
    cyc(1);
    tick_1s = 1'b0;
    @(negedge CP); chk("timeout_cv_next_cycle", int'(change_valid), 1);
    cyc(4);

    // Bounce: toggle every cycle across several ticks
    for (int i = 0; i < 30; i++) begin
      coin10    = i[0];
      tick_20ms = (i % 3 == 0);
      cyc(1);
    end
    coin10 = 1'b0; tick_20ms = 1'b0;
    repeat (3) t20();
    @(negedge CP); chk("toggle_amount", int'(amount), 0); chk("toggle_busy", int'(busy), 0);

    // Bounce: high for a single tick sample only
    press(0, 1, 0, 1);
    @(negedge CP); chk("onetick_amount", int'(amount), 0); chk("onetick_busy", int'(busy), 0);

    // Long hold: exactly one event
    press(0, 1, 0, 50);
    @(negedge CP); chk("hold_amount", int'(amount), 10);
    sb_q.push_back(mk(10, 10, 0));
    press(0, 0, 1, 3);

    // Simultaneous coins from IDLE
    press(1, 1, 0, 3);
    @(negedge CP); chk("both_coins_amount", int'(amount), 15);
    sb_q.push_back(mk(15, 15, 0));
    press(0, 0, 1, 3);

    // coin10 + cancel together in COLLECT at 10
    press(0, 1, 0, 3);
    sb_q.push_back(mk(20, 20, 0));
    press(0, 1, 1, 3);
    @(negedge CP); chk("coin_cancel_idle", int'(busy), 0);

    // Reset mid-dispense: no change_valid must follow
    press(0, 1, 0, 3);
    press(0, 1, 0, 3);
    press(0, 1, 0, 3);
    sec();
    @(negedge CP); chk("rst_pre_dispense", int'(dispense), 1);
    CR = 1'b1;
    cyc(1);
    CR = 1'b0;
    @(negedge CP);
    chk("rst_amount", int'(amount), 0);
    chk("rst_dispense", int'(dispense), 0);
    chk("rst_change", int'(change), 0);
    chk("rst_change_valid", int'(change_valid), 0);
    chk("rst_busy", int'(busy), 0);
    repeat (4) sec();

    cyc(5);
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
